// File: rtl/bus_slave_ram.sv
// Single-port RAM bus slave: latches a request in IDLE, inserts WAIT_STATES wait
// cycles, then pulses ack for one cycle; writes commit at the end of the ack cycle.
module bus_slave_ram #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_DEPTH     = 256,
    parameter int ADDR_LSB      = 2,
    parameter int WAIT_STATES   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic                     cmd,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic                     ack,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     busy
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [3:0]            cnt_reg, cnt_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic                  cmd_reg, cmd_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic                  ack_reg, ack_next;
    logic                  busy_reg, busy_next;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  mem_we;
    logic                  mem_re;
    logic                  addr_unused;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Address bits outside the word index alias onto the same words.
    assign addr_unused = ^addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            idx_reg   <= '0;
            cmd_reg   <= 1'b0;
            wdata_reg <= '0;
            ack_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            cmd_reg   <= cmd_next;
            wdata_reg <= wdata_next;
            ack_reg   <= ack_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        cmd_next   = cmd_reg;
        wdata_next = wdata_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    idx_next   = addr[ADDR_LSB +: IDX_W];
                    cmd_next   = cmd;
                    wdata_next = wdata;
                    if (WAIT_STATES > 0) begin
                        state_next = ST_WAIT;
                        cnt_next   = WAIT_LOAD;
                    end else begin
                        state_next = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = ST_ACK;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // ack/busy are registered alongside the state so they line up with it exactly.
    always_comb begin
        ack_next  = (state_next == ST_ACK);
        busy_next = (state_next != ST_IDLE);
        mem_we    = (state_reg == ST_ACK) && cmd_reg;
        mem_re    = (state_next == ST_ACK) && !cmd_next;
    end

    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[idx_reg] <= wdata_reg;
        end
    end

    // Read port uses the next index so a zero-wait read can go straight from IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_reg <= '0;
        end else if (mem_re) begin
            rdata_reg <= mem[idx_next];
        end
    end

    assign ack   = ack_reg;
    assign busy  = busy_reg;
    assign rdata = rdata_reg;

endmodule

// File: tb/tb_bus_slave_ram.sv
// Bench for bus_slave_ram: three instances (WAIT_STATES 1, 0, 3) driven from a
// vector table plus hand-written back-to-back, reset-abort and input-hold sequences.
`timescale 1ns/1ps
module tb_bus_slave_ram;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset [N];
    logic        req   [N];
    logic        cmd   [N];
    logic [31:0] addr  [N];
    logic [31:0] wdata [N];
    logic [31:0] rdata [N];
    logic        ack   [N];
    logic        busy  [N];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            bus_slave_ram #(
                .ADDRESS_WIDTH(32),
                .DATA_WIDTH   (32),
                .MEM_DEPTH    (256),
                .ADDR_LSB     (2),
                .WAIT_STATES  ((gi == 0) ? 1 : ((gi == 1) ? 0 : 3))
            ) u_dut (
                .clk  (clk),
                .reset(reset[gi]),
                .req  (req[gi]),
                .addr (addr[gi]),
                .cmd  (cmd[gi]),
                .wdata(wdata[gi]),
                .ack  (ack[gi]),
                .rdata(rdata[gi]),
                .busy (busy[gi])
            );
        end
    endgenerate

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          dut;
        string       tag;
        logic [31:0] exp_rdata;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        int          dut;
        bit          cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[$];

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge. Latency is the number of edges after the
    // request-sampling edge until ack is seen high (ack is then sampled one edge later).
    task automatic run_txn(input int d, input bit c, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_rd,
                           input bit perturb, input string tag);
        sb_t e;
        int  cyc;
        int  busy_cyc;
        e.dut = d;
        e.tag = tag;
        e.exp_rdata = exp_rd;
        sb_q.push_back(e);
        req[d] = 1'b1; cmd[d] = c; addr[d] = a; wdata[d] = wd;
        @(posedge clk); #1;
        if (perturb) begin
            addr[d] = ~a; wdata[d] = ~wd; cmd[d] = ~c;
        end
        cyc = 0;
        busy_cyc = 0;
        while (!ack[d] && cyc < 20) begin
            if (busy[d]) busy_cyc++;
            @(posedge clk); #1;
            cyc++;
        end
        if (busy[d]) busy_cyc++;
        req[d] = 1'b0;
        check($sformatf("%s latency", tag), cyc, ws_of(d));
        check($sformatf("%s busy_cycles", tag), busy_cyc, ws_of(d) + 1);
        e = sb_q.pop_front();
        check($sformatf("%s rdata", e.tag), rdata[e.dut], e.exp_rdata);
        $display("txn %s dut=%0d cmd=%0d addr=%h wdata=%h rdata=%h cycles=%0d",
                 tag, d, c, a, wd, rdata[d], cyc);
        @(posedge clk); #1;
        check($sformatf("%s ack_width", tag), ack[d], 1'b0);
        check($sformatf("%s busy_end", tag), busy[d], 1'b0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        sb_t e;
        int  ack_cnt;
        for (int d = 0; d < N; d++) begin
            reset[d] = 1'b1; req[d] = 1'b0; cmd[d] = 1'b0;
            addr[d] = '0; wdata[d] = '0;
        end

        vecs.push_back('{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000});
        vecs.push_back('{0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF});
        vecs.push_back('{0, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 32'hDEAD_BEEF});
        vecs.push_back('{0, 1'b1, 32'h0000_0400, 32'hA5A5_A5A5, 32'hDEAD_BEEF});
        vecs.push_back('{0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hA5A5_A5A5});
        vecs.push_back('{0, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h0BAD_F00D});
        vecs.push_back('{0, 1'b1, 32'h0000_03FC, 32'hFFFF_0001, 32'h0BAD_F00D});
        vecs.push_back('{0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'hFFFF_0001});
        vecs.push_back('{0, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'hDEAD_BEEF});
        vecs.push_back('{1, 1'b1, 32'h0000_0044, 32'h5555_AAAA, 32'h0000_0000});
        vecs.push_back('{1, 1'b0, 32'h0000_0044, 32'h0000_0000, 32'h5555_AAAA});
        vecs.push_back('{2, 1'b1, 32'h0000_0008, 32'h0000_0000, 32'h0000_0000});
        vecs.push_back('{2, 1'b1, 32'h0000_000C, 32'h0000_0077, 32'h0000_0000});
        vecs.push_back('{2, 1'b0, 32'h0000_000C, 32'h0000_0000, 32'h0000_0077});

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < N; d++) begin
            check($sformatf("reset ack d%0d", d), ack[d], 1'b0);
            check($sformatf("reset busy d%0d", d), busy[d], 1'b0);
            check($sformatf("reset rdata d%0d", d), rdata[d], 32'h0);
            reset[d] = 1'b0;
        end

        for (int i = 0; i < vecs.size(); i++) begin
            run_txn(vecs[i].dut, vecs[i].cmd, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_rdata, 1'b0, $sformatf("vec%0d", i));
        end

        // Zero-wait back-to-back: write then read of the same word with req held.
        req[1] = 1'b1; cmd[1] = 1'b1; addr[1] = 32'h4; wdata[1] = 32'h1111_1111;
        @(posedge clk); #1;
        check("b2b ack1", ack[1], 1'b1);
        cmd[1] = 1'b0; wdata[1] = 32'h0;
        e.dut = 1; e.tag = "b2b read"; e.exp_rdata = 32'h1111_1111;
        sb_q.push_back(e);
        @(posedge clk); #1;
        check("b2b gap ack", ack[1], 1'b0);
        check("b2b gap busy", busy[1], 1'b0);
        check("b2b write keeps rdata", rdata[1], 32'h5555_AAAA);
        @(posedge clk); #1;
        check("b2b ack2", ack[1], 1'b1);
        e = sb_q.pop_front();
        check(e.tag, rdata[e.dut], e.exp_rdata);
        $display("txn b2b dut=1 read addr=00000004 rdata=%h", rdata[1]);
        req[1] = 1'b0;
        @(posedge clk); #1;
        check("b2b ack_end", ack[1], 1'b0);

        // Reset during WAIT aborts the write and clears rdata (currently 0x77).
        req[2] = 1'b1; cmd[2] = 1'b1; addr[2] = 32'h8; wdata[2] = 32'h1234_5678;
        @(posedge clk); #1;
        check("rst busy in wait", busy[2], 1'b1);
        req[2] = 1'b0;
        @(posedge clk); #1;
        reset[2] = 1'b1;
        @(posedge clk); #1;
        check("rst busy", busy[2], 1'b0);
        check("rst ack", ack[2], 1'b0);
        check("rst rdata", rdata[2], 32'h0);
        reset[2] = 1'b0;
        ack_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (ack[2]) ack_cnt++;
        end
        check("rst no ack", ack_cnt, 0);
        $display("txn reset_abort dut=2 addr=00000008 acks_after=%0d", ack_cnt);
        run_txn(2, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0, "rst readback");

        // Inputs changed after sampling must not affect the transaction.
        run_txn(2, 1'b1, 32'h8, 32'hCAFE_0001, 32'h0, 1'b1, "hold write");
        run_txn(2, 1'b0, 32'h8, 32'h0, 32'hCAFE_0001, 1'b1, "hold read");
        run_txn(2, 1'b0, 32'hC, 32'h0, 32'h0000_0077, 1'b0, "hold other word");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_slave_ram.md
BUS_SLAVE_RAM -- requirements
Module: bus_slave_ram

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32: width of addr SHALL be ADDRESS_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 32: width of wdata/rdata SHALL be DATA_WIDTH.
REQ-003 Parameter MEM_DEPTH, default 256: number of DATA_WIDTH words SHALL be MEM_DEPTH (power of two, >=2).
REQ-004 Parameter ADDR_LSB, default 2: lowest addr bit used for word index SHALL be ADDR_LSB (bits below are consumed by crossbar slave select).
REQ-005 Parameter WAIT_STATES, default 1: wait cycles inserted before ack SHALL be WAIT_STATES (range 0..15).
REQ-006 clk  input  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 req  input  1  transaction request from master/crossbar.
REQ-009 addr  input  ADDRESS_WIDTH  byte address; held stable by master while req high until ack.
REQ-010 cmd  input  1  1 = write, 0 = read; held with addr.
REQ-011 wdata  input  DATA_WIDTH  write data; held with addr.
REQ-012 ack  output  1  one-cycle completion pulse.
REQ-013 rdata  output  DATA_WIDTH  read data, valid in ack cycle of a read.
REQ-014 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, ACK.
REQ-016 IDLE: req=1 SHALL latch addr index, cmd, wdata and go to WAIT if WAIT_STATES>0, else ACK; req=0 SHALL stay IDLE.
REQ-017 Word index SHALL be addr[ADDR_LSB +: log2(MEM_DEPTH)]; higher addr bits ignored (aliasing, no error).
REQ-018 WAIT: 4-bit counter loaded with WAIT_STATES-1 on entry, decremented each cycle; at 0 SHALL go to ACK.
REQ-019 ACK: ack=1 for exactly that cycle, then unconditionally IDLE.
REQ-020 Latency: ack SHALL be high exactly WAIT_STATES+1 cycles after the edge at which req was sampled high in IDLE.
REQ-021 Write: mem[index] <= latched wdata at the edge ending the ACK cycle; no write in any other state.
REQ-022 Read: rdata SHALL present mem[index] in the ACK cycle, registered; rdata SHALL hold its value until the next read ack (write acks leave rdata unchanged).
REQ-023 Inputs SHALL be ignored in WAIT and ACK; only latched values used.
REQ-024 req high in IDLE immediately after ACK SHALL start a new transaction (back-to-back period WAIT_STATES+2 cycles).
REQ-025 Read of a location written by the immediately preceding transaction SHALL return the new data.
REQ-026 busy SHALL be registered from state (1 in WAIT and ACK).
REQ-027 Memory contents SHALL NOT be cleared by reset; unwritten locations are undefined.

Reset
REQ-028 reset=1 SHALL force state IDLE, ack=0, busy=0, rdata=0, wait counter=0 at next edge.
REQ-029 reset in WAIT or ACK SHALL abort the transaction: no ack, no memory write, latched request discarded.
REQ-030 reset has priority over req in the same cycle; first transaction may start on the first edge with reset=0.

Verification
REQ-031 WAIT_STATES=1: write req addr=0x0000_0010 wdata=0xDEAD_BEEF -> ack high exactly 2 cycles after req sampled, one cycle wide, busy high 2 cycles.
REQ-032 Then read addr=0x0000_0010 -> ack 2 cycles later with rdata=0xDEAD_BEEF; rdata holds through a subsequent write ack.
REQ-033 WAIT_STATES=0, back-to-back: write 0x4->0x1111_1111, req held, read 0x4 -> acks every 2 cycles, read returns 0x1111_1111.
REQ-034 Aliasing MEM_DEPTH=256: write addr=0x0000_0400 data=0xA5A5_A5A5, read addr=0x0000_0000 -> rdata=0xA5A5_A5A5.
REQ-035 WAIT_STATES=3: write 0x8->0x1234_5678, reset pulsed in WAIT -> no ack, busy=0, rdata=0; prior value at 0x8 (0x0) read back unchanged.
REQ-036 Changing addr/wdata during WAIT -> ignored; memory and rdata reflect values latched at request.
